// File: rtl/sequence_detector.sv
// sequence_detector: shifts in an 8-bit frame MSB-first after start and reports which table entry it matches.
module sequence_detector #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       busy,
    output logic       done,
    output logic       match,
    output logic [2:0] index,
    output logic [7:0] rx_byte,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW:0] TLIM = (TW + 1)'(TIMEOUT);
    localparam logic [7:0] TABLE [8] = '{8'hF7, 8'h01, 8'h95, 8'h55, 8'hAB, 8'hB8, 8'hBB, 8'hBE};
    state_t state, state_nx;
    logic [7:0] sr, sr_nx;
    logic [3:0] bcnt;
    logic [TW-1:0] tcnt;
    logic [TW:0] tinc;
    logic last, expire, hit;
    logic [2:0] hit_idx;
    always_comb begin
        tinc = {1'b0, tcnt} + 1'b1;
        sr_nx = {sr[6:0], bit_in};
        last = bit_valid && bcnt == 4'd7;
        expire = TIMEOUT != 0 && !bit_valid && tinc == TLIM;
        hit = 1'b0;
        hit_idx = 3'd0;
        // entries are unique, so at most one hit and no priority is needed
        for (int i = 0; i < 8; i++)
            if (sr_nx == TABLE[i]) begin
                hit = 1'b1;
                hit_idx = 3'(i);
            end
        state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (last ? REPORT : expire ? IDLE : SHIFT) : IDLE;
    end
    assign busy = state != IDLE;
    assign done = state == REPORT;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr <= '0;
            bcnt <= '0;
            tcnt <= '0;
            match <= 1'b0;
            index <= '0;
            rx_byte <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            timeout_err <= state == SHIFT && expire;
            if (state == IDLE && start) begin
                sr <= '0;
                bcnt <= '0;
                tcnt <= '0;
            end
            if (state == SHIFT && bit_valid) begin
                sr <= sr_nx;
                bcnt <= bcnt + 4'd1;
                tcnt <= '0;
            end else if (state == SHIFT) begin
                tcnt <= tinc[TW] ? tcnt : tinc[TW-1:0];
            end
            if (state == SHIFT && last) begin
                rx_byte <= sr_nx;
                match <= hit;
                index <= hit_idx;
            end
        end
    end
endmodule

// File: tb/tb_sequence_detector.sv
// tb_sequence_detector: directed frames checked against a queue-based receiver model every cycle.
module tb_sequence_detector;
    localparam int TO = 10;
    logic clk = 0, reset = 1, start = 0, bit_in = 0, bit_valid = 0;
    logic busy, done, match, timeout_err;
    logic [2:0] index;
    logic [7:0] rx_byte;
    int n_cmp = 0, n_bad = 0, done_cnt = 0;
    sequence_detector #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .busy(busy), .done(done), .match(match), .index(index),
        .rx_byte(rx_byte), .timeout_err(timeout_err));
    always #5 clk = ~clk;
    logic [7:0] tbl [8] = '{8'hF7, 8'h01, 8'h95, 8'h55, 8'hAB, 8'hB8, 8'hBB, 8'hBE};
    bit q[$];
    bit collecting = 0, e_done = 0, e_to = 0, e_match = 0, armed = 0;
    int gap = 0;
    logic [2:0] e_idx = 0;
    logic [7:0] e_rx = 0;
    always @(posedge clk) begin
        if (reset) begin
            collecting = 0; q.delete(); e_done = 0; e_to = 0; e_match = 0; e_idx = 0; e_rx = 0; armed = 1;
        end else begin
            e_to = 0;
            if (e_done) e_done = 0;
            else if (!collecting) begin
                if (start) begin collecting = 1; q.delete(); gap = 0; end
            end else if (bit_valid) begin
                q.push_back(bit_in);
                gap = 0;
                if (q.size() == 8) begin
                    e_rx = 0;
                    foreach (q[k]) e_rx = e_rx * 2 + 8'(q[k]);
                    e_match = 0; e_idx = 0;
                    foreach (tbl[k]) if (tbl[k] == e_rx) begin e_match = 1; e_idx = 3'(k); end
                    collecting = 0; e_done = 1;
                end
            end else begin
                gap++;
                if (gap == TO) begin collecting = 0; e_to = 1; end
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (armed) begin
        if (done) done_cnt++;
        chk("m_done", done, e_done);
        chk("m_busy", busy, collecting || e_done);
        chk("m_timeout", timeout_err, e_to);
        chk("m_match", match, e_match);
        chk("m_index", index, e_idx);
        chk("m_rx", rx_byte, e_rx);
    end
    task automatic tick; @(posedge clk); #1; endtask
    // sv: drive bit_valid in the start cycle with a decoy 1; hs: hold start high through the frame
    task automatic frame(input logic [7:0] b, input int g, input bit sv, input bit hs,
                         input bit xm, input int xi);
        int d0;
        d0 = done_cnt;
        start = 1; bit_valid = sv; bit_in = 1; tick;
        start = hs;
        for (int i = 7; i >= 0; i--) begin
            bit_valid = 0;
            repeat ((g + i) % 6 * (g > 0 ? 1 : 0)) tick;
            bit_valid = 1; bit_in = b[i]; tick;
        end
        bit_valid = 0;
        chk("lit_done", done, 1);
        chk("lit_rx", rx_byte, b);
        chk("lit_match", match, xm);
        chk("lit_index", index, xi);
        tick;
        start = 0;
        chk("lit_done_gone", done, 0);
        chk("lit_busy_gone", busy, 0);
        tick;
        chk("done_once", done_cnt - d0, 1);
    endtask
    initial begin
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_rx", rx_byte, 0);
        reset = 0; tick;
        frame(8'hB8, 0, 0, 0, 1, 5);
        for (int k = 0; k < 8; k++) frame(tbl[k], k + 1, 0, 0, 1, k);
        frame(8'h00, 0, 0, 0, 0, 0);
        frame(8'hFF, 2, 0, 0, 0, 0);
        frame(8'h01, 0, 1, 0, 1, 1);
        start = 1; tick; start = 0;
        for (int i = 0; i < 3; i++) begin bit_valid = 1; bit_in = 1; tick; end
        bit_valid = 0;
        repeat (9) tick;
        chk("to_early", timeout_err, 0);
        chk("to_busy_early", busy, 1);
        tick;
        chk("to_pulse", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_rx_kept", rx_byte, 8'h01);
        tick;
        chk("to_pulse_end", timeout_err, 0);
        frame(8'h95, 1, 0, 0, 1, 2);
        frame(8'hBE, 0, 0, 1, 1, 7);
        start = 1; tick; start = 0;
        for (int i = 0; i < 5; i++) begin bit_valid = 1; bit_in = i[0]; tick; end
        bit_valid = 0; reset = 1; tick; reset = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rx", rx_byte, 0);
        chk("mid_rst_match", match, 0);
        chk("mid_rst_index", index, 0);
        tick;
        frame(8'h55, 3, 0, 0, 1, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
